cache_refill_engine: RTL and testbench
======================================

// Module: cache_refill_engine
// PURPOSE
//  Line-fill stage directly downstream of the cache control FSM. The controller's
//  LOAD state (wrEn) pulses refill_req. This block fetches one full cache line,
//  word by word, from main RAM over a req/ack handshake, writes each word into the
//  data array, then writes tag+valid and pulses refill_done back to the controller.
// PARAMETERS
//  ADDR_W    15  word-address width (tag|index|offset)
//  WORD_W    8   data word width
//  OFFSET_W  2   log2(words per line); BW = 2**OFFSET_W
//  INDEX_W   5   log2(lines); localparam TAG_W = ADDR_W-INDEX_W-OFFSET_W (=8)
// PORTS
//  globalclock  in   1         single clock, rising edge
//  reset        in   1         async, active-high
//  refill_req   in   1         start line fill (sampled in IDLE only)
//  miss_addr    in   ADDR_W    missing word address, latched on accept
//  busy         out  1         high from accept cycle+1 through DONE
//  refill_done  out  1         one-cycle pulse, line complete
//  mem_req      out  1         RAM read request, held until mem_ack
//  mem_addr     out  ADDR_W    {tag,index,offset}, stable while mem_req=1
//  mem_ack      in   1         RAM ack; mem_rdata valid in same cycle
//  mem_rdata    in   WORD_W    RAM read data
//  cw_en        out  1         data-array write strobe
//  cw_index     out  INDEX_W   data-array line index
//  cw_offset    out  OFFSET_W  word within line
//  cw_data      out  WORD_W    write data (registered from mem_rdata)
//  tag_we       out  1         tag-array write strobe
//  tag_data     out  TAG_W     tag to write
//  tag_valid    out  1         valid bit to write
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; every output 0; counter, latched address 0.
//  - States: IDLE, INVAL, FETCH, WRITE, TAG, DONE. All strobes are decoded from state.
//  - IDLE: refill_req=1 latches miss_addr -> INVAL. busy=0.
//  - INVAL: tag_we=1, tag_valid=0 for the latched index, 1 cycle -> FETCH. A fill that
//    reset aborts therefore never leaves a stale-valid line. cnt=0.
//  - FETCH: mem_req=1, mem_addr={tag,index,off}. off=(start_off+cnt) mod BW and wraps
//    within the line. On mem_ack=1: mem_rdata -> cw_data register -> WRITE. Otherwise
//    stay, with mem_addr unchanged. Wait states are unbounded.
//  - WRITE: cw_en=1 with cw_index/cw_offset=off for 1 cycle, then cnt+1. If cnt was
//    BW-1 -> TAG, else -> FETCH.
//  - TAG: tag_we=1, tag_valid=1, tag_data=latched tag, 1 cycle -> DONE.
//  - DONE: refill_done=1 for 1 cycle -> IDLE. busy falls on the IDLE cycle.
//  - Latency with zero-wait RAM (ack in the first FETCH cycle): accept edge -> refill_done
//    high = 2*BW+3 cycles (11 at defaults). Each RAM wait cycle adds 1.
//  - refill_req outside IDLE is ignored; no queueing. mem_ack outside FETCH is ignored.
//  - mem_ack held high continuously is legal: one word is accepted per FETCH visit.
//  - cnt is OFFSET_W+1 bits wide. The offset sum is truncated to OFFSET_W bits (wrap).
// CONFIGURATION
//  CRITICAL_WORD_FIRST_EN defined: start_off = miss_addr[OFFSET_W-1:0]. The missed
//    word is fetched and written first, and the line wraps (e.g. 2,3,0,1).
//  Undefined: start_off = 0. Words are always fetched 0..BW-1. Timing is otherwise
//    identical.
// TESTING
//  1 Reset mid-FETCH (after 2 words) -> next cycle all outputs 0, state IDLE; a new
//    refill_req then starts again with INVAL.
//  2 No macro, miss_addr=15'h1234 (tag 8'h24, index 5'h0D, off 0), zero-wait RAM
//    -> mem_addr 1234,1235,1236,1237; 4 cw_en pulses with offsets 0..3; tag_we
//    tag=24 valid=1; refill_done 11 cycles after accept.
//  3 CRITICAL_WORD_FIRST_EN, miss_addr=15'h1236 -> mem_addr 1236,1237,1234,1235;
//    cw_offset 2,3,0,1; done timing same as scenario 2.
//  4 mem_ack delayed 3 cycles on word 1 -> mem_req and mem_addr stable for 4 cycles;
//    cw_data equals the mem_rdata sampled at the ack; refill_done at 14 cycles.
//  5 refill_req held high through the whole fill -> exactly one fill. After DONE,
//    IDLE re-accepts the request (back-to-back fill); busy is low for 1 cycle between.
//  6 mem_ack tied high -> one word per FETCH visit, 4 cw_en pulses total, no extra
//    writes.

Source files
------------

// File: rtl/cache_refill_engine.sv
// Line-fill engine: fetches one cache line word by word from main RAM and writes it into the data/tag arrays.
// Latency: accept edge to refill_done high is 2*BW+3 cycles with zero-wait RAM; each RAM wait cycle adds one.
// Backpressure: mem_req is held until mem_ack; wait states are unbounded; refill_req outside IDLE is ignored.
//
// Ports:
//   globalclock_i / reset_i    : single rising-edge clock, asynchronous active-high reset
//   refill_req_i / miss_addr_i : fill request from the cache controller; the address is latched on accept
//   busy_o / refill_done_o     : fill in progress / one-cycle completion pulse
//   mem_req_o / mem_addr_o     : RAM read request {tag,index,offset}, held stable until mem_ack_i
//   mem_ack_i / mem_rdata_i    : RAM acknowledge, with the read data valid in the same cycle
//   cw_en_o / cw_index_o / cw_offset_o / cw_data_o : data-array write port
//   tag_we_o / tag_data_o / tag_valid_o            : tag-array write port (index on cw_index_o)
// Optional feature: define CRITICAL_WORD_FIRST_EN to start the fill at the missed word and wrap.
module cache_refill_engine #(
    parameter int ADDR_W   = 15,
    parameter int WORD_W   = 8,
    parameter int OFFSET_W = 2,
    parameter int INDEX_W  = 5
) (
    input  logic                                 globalclock_i,
    input  logic                                 reset_i,
    input  logic                                 refill_req_i,
    input  logic [ADDR_W-1:0]                    miss_addr_i,
    output logic                                 busy_o,
    output logic                                 refill_done_o,
    output logic                                 mem_req_o,
    output logic [ADDR_W-1:0]                    mem_addr_o,
    input  logic                                 mem_ack_i,
    input  logic [WORD_W-1:0]                    mem_rdata_i,
    output logic                                 cw_en_o,
    output logic [INDEX_W-1:0]                   cw_index_o,
    output logic [OFFSET_W-1:0]                  cw_offset_o,
    output logic [WORD_W-1:0]                    cw_data_o,
    output logic                                 tag_we_o,
    output logic [ADDR_W-INDEX_W-OFFSET_W-1:0]   tag_data_o,
    output logic                                 tag_valid_o
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int CNT_W = OFFSET_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << OFFSET_W) - 1);

`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_INVAL, S_FETCH, S_WRITE, S_TAG, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   cw_data_q, cw_data_d;

    logic [TAG_W-1:0]    line_tag;
    logic [INDEX_W-1:0]  line_idx;
    logic [OFFSET_W-1:0] start_off;
    logic [OFFSET_W-1:0] cur_off;

    assign line_tag  = addr_q[ADDR_W-1 -: TAG_W];
    assign line_idx  = addr_q[OFFSET_W +: INDEX_W];
    assign start_off = CWF ? addr_q[OFFSET_W-1:0] : '0;
    // Truncating add makes the word sequence wrap inside the line.
    assign cur_off   = start_off + cnt_q[OFFSET_W-1:0];

    // State register
    always_ff @(posedge globalclock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge globalclock_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q    <= '0;
            cnt_q     <= '0;
            cw_data_q <= '0;
        end else begin
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            cw_data_q <= cw_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (refill_req_i) state_d = S_INVAL;
            S_INVAL: state_d = S_FETCH;
            S_FETCH: if (mem_ack_i) state_d = S_WRITE;
            S_WRITE: state_d = (cnt_q == LAST_CNT) ? S_TAG : S_FETCH;
            S_TAG:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        cw_data_d = cw_data_q;
        case (state_q)
            S_IDLE:  if (refill_req_i) addr_d = miss_addr_i;
            S_INVAL: cnt_d = '0;
            S_FETCH: if (mem_ack_i) cw_data_d = mem_rdata_i;
            S_WRITE: cnt_d = cnt_q + CNT_W'(1);
            default: ;
        endcase
    end

    // Outputs decoded from state; address fields are zero outside the states that use them.
    always_comb begin
        busy_o        = (state_q != S_IDLE);
        refill_done_o = 1'b0;
        mem_req_o     = 1'b0;
        mem_addr_o    = '0;
        cw_en_o       = 1'b0;
        cw_index_o    = '0;
        cw_offset_o   = '0;
        tag_we_o      = 1'b0;
        tag_data_o    = '0;
        tag_valid_o   = 1'b0;
        case (state_q)
            S_INVAL: begin
                // Clear valid before any data word lands, so an aborted fill leaves no stale line.
                tag_we_o   = 1'b1;
                cw_index_o = line_idx;
                tag_data_o = line_tag;
            end
            S_FETCH: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {line_tag, line_idx, cur_off};
            end
            S_WRITE: begin
                cw_en_o     = 1'b1;
                cw_index_o  = line_idx;
                cw_offset_o = cur_off;
            end
            S_TAG: begin
                tag_we_o    = 1'b1;
                tag_valid_o = 1'b1;
                cw_index_o  = line_idx;
                tag_data_o  = line_tag;
            end
            S_DONE:  refill_done_o = 1'b1;
            default: ;
        endcase
    end

    assign cw_data_o = cw_data_q;

endmodule

// File: tb/tb_cache_refill_engine.sv
module tb_cache_refill_engine;
    localparam int BW = 4;
`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif
    localparam int K_INV = 0, K_RD = 1, K_WR = 2, K_TAG = 3, K_DN = 4;

    typedef struct { int kind; int x; int y; int z; } ev_t;
    typedef struct { int waits; int data; } ramw_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        refill_req = 1'b0;
    logic [14:0] miss_addr = '0;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        busy, refill_done, mem_req, cw_en, tag_we, tag_valid;
    logic [14:0] mem_addr;
    logic [4:0]  cw_index;
    logic [1:0]  cw_offset;
    logic [7:0]  cw_data, tag_data;

    cache_refill_engine dut (
        .globalclock_i (clk),
        .reset_i       (rst),
        .refill_req_i  (refill_req),
        .miss_addr_i   (miss_addr),
        .busy_o        (busy),
        .refill_done_o (refill_done),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata),
        .cw_en_o       (cw_en),
        .cw_index_o    (cw_index),
        .cw_offset_o   (cw_offset),
        .cw_data_o     (cw_data),
        .tag_we_o      (tag_we),
        .tag_data_o    (tag_data),
        .tag_valid_o   (tag_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_done = 0;
    ev_t   exp_q[$];
    ramw_t ram_q[$];
    int blo[$], bhi[$];
    bit ack_tie = 1'b0;
    bit rsp_have = 1'b0;
    int rsp_rem = 0;
    int rsp_data = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic got(input ev_t a);
        ev_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: kind %0d x=%0h y=%0h z=%0h, expected no event (cycle %0d)",
                     a.kind, a.x, a.y, a.z, cyc);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("ev%0d_kind", e.kind), a.kind, e.kind);
            check($sformatf("ev%0d_x", e.kind), a.x, e.x);
            check($sformatf("ev%0d_y", e.kind), a.y, e.y);
            check($sformatf("ev%0d_z", e.kind), a.z, e.z);
        end
    endtask

    // Monitor: samples on the falling edge and checks every output event against the queue.
    initial begin
        bit eb;
        int req_run;
        logic [14:0] prev_addr;
        req_run = 0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_run = 0;
                check("reset_outputs", longint'({busy, refill_done, mem_req, mem_addr, cw_en, cw_index,
                      cw_offset, cw_data, tag_we, tag_data, tag_valid}), 0);
            end else begin
                eb = 1'b0;
                foreach (blo[i]) if (cyc >= blo[i] && cyc <= bhi[i]) eb = 1'b1;
                check("busy", busy, eb);
                if (mem_req) begin
                    req_run++;
                    if (req_run > 1) check("mem_addr_stable", mem_addr, prev_addr);
                    prev_addr = mem_addr;
                    if (mem_ack) begin
                        got('{K_RD, int'(mem_addr), req_run, 0});
                        req_run = 0;
                    end
                end else begin
                    req_run = 0;
                end
                if (cw_en) got('{K_WR, int'(cw_index), int'(cw_offset), int'(cw_data)});
                if (tag_we) begin
                    if (tag_valid) got('{K_TAG, int'(cw_index), 1, int'(tag_data)});
                    else           got('{K_INV, int'(cw_index), 0, 0});
                end
                if (refill_done) got('{K_DN, cyc, 0, 0});
            end
        end
    end

    // RAM responder: serves planned words in order with their planned wait counts.
    initial begin
        ramw_t r;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && !rst) begin
                if (!rsp_have) begin
                    if (ram_q.size() > 0) begin
                        r = ram_q.pop_front();
                        rsp_rem = r.waits;
                        rsp_data = r.data;
                    end else begin
                        rsp_rem = 0;
                        rsp_data = 8'hEE;
                    end
                    rsp_have = 1'b1;
                end
                if (rsp_rem == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = rsp_data[7:0];
                    rsp_have = 1'b0;
                end else begin
                    rsp_rem--;
                    mem_ack = 1'b0;
                    mem_rdata = 8'($urandom);
                end
            end else begin
                mem_ack = ack_tie ? 1'b1 : ($urandom_range(0, 3) == 0);
                mem_rdata = 8'($urandom);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: the whole fill described as an ordered list of events, with the
    // request accepted on the edge that ends cycle c.
    task automatic plan(input logic [14:0] addr, input int c, input int mode, output int done);
        ramw_t r;
        int tg, ix, st, off, w, sumw;
        tg = int'(addr[14:7]);
        ix = int'(addr[6:2]);
        st = CWF ? int'(addr[1:0]) : 0;
        sumw = 0;
        exp_q.push_back('{K_INV, ix, 0, 0});
        for (int k = 0; k < BW; k++) begin
            case (mode)
                1: w = $urandom_range(0, 3);
                2: w = (k == 1) ? 3 : 0;
                3: w = (k == 2) ? 6 : 0;
                default: w = 0;
            endcase
            r.waits = w;
            r.data = $urandom_range(0, 255);
            ram_q.push_back(r);
            off = (st + k) % BW;
            exp_q.push_back('{K_RD, tg * 128 + ix * 4 + off, w + 1, 0});
            exp_q.push_back('{K_WR, ix, off, r.data});
            sumw += w;
        end
        exp_q.push_back('{K_TAG, ix, 1, tg});
        done = c + 2 * BW + 3 + sumw;
        exp_q.push_back('{K_DN, done, 0, 0});
        blo.push_back(c + 1);
        bhi.push_back(done);
        last_done = done;
    endtask

    task automatic do_fill(input logic [14:0] addr, input int mode, input int hold);
        int d;
        while (cyc <= last_done) step();
        plan(addr, cyc, mode, d);
        miss_addr = addr;
        refill_req = 1'b1;
        step();
        miss_addr = 15'($urandom);
        repeat (hold) step();
        refill_req = 1'b0;
    endtask

    task automatic reset_midfetch(input logic [14:0] addr);
        int d, c;
        while (cyc <= last_done) step();
        c = cyc;
        plan(addr, c, 3, d);
        miss_addr = addr;
        refill_req = 1'b1;
        step();
        refill_req = 1'b0;
        while (cyc < c + 7) step();
        check("reset_pending_events", exp_q.size(), 6);
        rst = 1'b1;
        exp_q.delete();
        ram_q.delete();
        blo.delete();
        bhi.delete();
        rsp_have = 1'b0;
        step();
        step();
        rst = 1'b0;
        last_done = cyc;
    endtask

    task automatic back_to_back(input logic [14:0] a1, input logic [14:0] a2);
        int d1, d2, c2;
        while (cyc <= last_done) step();
        plan(a1, cyc, 1, d1);
        miss_addr = a1;
        refill_req = 1'b1;
        step();
        miss_addr = a2;
        c2 = d1 + 1;
        plan(a2, c2, 0, d2);
        while (cyc < c2 + 1) step();
        refill_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached with %0d events outstanding, expected 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        last_done = cyc;
        do_fill(15'h1234, 0, 0);
        do_fill(15'h1236, 0, 0);
        do_fill(15'h0A5F, 2, 0);
        reset_midfetch(15'h7FFD);
        do_fill(15'h3333, 0, 0);
        back_to_back(15'h0101, 15'h5ABC);
        ack_tie = 1'b1;
        do_fill(15'h2467, 0, 0);
        do_fill(15'h6C01, 0, 2);
        while (cyc <= last_done) step();
        ack_tie = 1'b0;
        for (int i = 0; i < 25; i++) do_fill(15'($urandom), 1, $urandom_range(0, 4));
        while (cyc <= last_done + 2) step();
        check("leftover_events", exp_q.size(), 0);
        check("leftover_ram_words", ram_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
